multiplier_ctrl: RTL and testbench

- Sequencing controller plus datapath for the memory-mapped multiplier peripheral; sits behind the bus slave and is driven by it.
- The slave supplies op_start, op_clear and two 64-bit operands; this block returns the 128-bit product and the 2-bit state.
- It runs a signed radix-4 Booth multiply, one step per clock, and holds the product until software clears it.

---
 rtl/multiplier_ctrl.sv | 127 ++++++++++++
 tb/tb_multiplier_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multiplier_ctrl.sv
// Sequencing controller and datapath for the memory-mapped multiplier peripheral.
// Signed radix-4 Booth multiply, one step per clock; product held until cleared.
module multiplier_ctrl #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   result,
    output logic [1:0]           state
);

    localparam int unsigned STEPS = WIDTH / 2;
    localparam int unsigned AW    = WIDTH + 2;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DONE = 2'b01,
        EXEC = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   result_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [AW-1:0]        a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 start_d;
    logic                 start_pulse;
    logic [AW-1:0]        m_ext, m_dbl, addend, sum;

    assign start_pulse = op_start & ~start_d;
    assign m_ext       = {{2{m_q[WIDTH-1]}}, m_q};
    assign m_dbl       = {m_q[WIDTH-1], m_q, 1'b0};
    assign state       = state_q;

    // Next-state, datapath step and result update
    always_comb begin
        state_d  = state_q;
        result_d = result;
        m_d      = m_q;
        a_d      = a_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        count_d  = count_q;
        addend   = '0;
        sum      = '0;

        case (state_q)
            IDLE: begin
                if (op_clear) begin
                    result_d = '0;
                end else if (start_pulse) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    count_d = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_clear) begin
                    state_d  = IDLE;
                    result_d = '0;
                    count_d  = '0;
                end else begin
                    case ({q_q[1:0], qm1_q})
                        3'b001, 3'b010: addend = m_ext;
                        3'b011:         addend = m_dbl;
                        3'b100:         addend = -m_dbl;
                        3'b101, 3'b110: addend = -m_ext;
                        default:        addend = '0;
                    endcase
                    sum     = a_q + addend;
                    // Arithmetic shift of {A,Q,q_m1} right by two
                    a_d     = {{2{sum[AW-1]}}, sum[AW-1:2]};
                    q_d     = {sum[1:0], q_q[WIDTH-1:2]};
                    qm1_d   = q_q[1];
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(STEPS - 1)) begin
                        result_d = {a_d[WIDTH-1:0], q_d};
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (op_clear) begin
                    state_d  = IDLE;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            result  <= '0;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            count_q <= '0;
            start_d <= 1'b0;
        end else begin
            state_q <= state_d;
            result  <= result_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            count_q <= count_d;
            start_d <= op_start;
        end
    end

endmodule

// File: tb/tb_multiplier_ctrl.sv
// Self-checking bench for multiplier_ctrl: directed corner operands plus random
// operands compared against a plain wide-multiply reference.
module tb_multiplier_ctrl;

    localparam int unsigned W     = 64;
    localparam int unsigned STEPS = W / 2;
    localparam int unsigned LIMIT = 200;

    logic             clk;
    logic             reset_n;
    logic             op_start;
    logic             op_clear;
    logic [W-1:0]     multiplicand;
    logic [W-1:0]     multiplier;
    logic [2*W-1:0]   result;
    logic [1:0]       state;

    int n_checks = 0;
    int n_pass   = 0;

    multiplier_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result       (result),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
        logic signed [2*W-1:0] me, qe;
        me = {{W{m[W-1]}}, m};
        qe = {{W{q[W-1]}}, q};
        return me * qe;
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Start an operation, scramble operands while it runs, then check DONE hold and clear
    task automatic do_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] q);
        logic [2*W-1:0] exp;
        int exec_cycles;
        int cyc;
        exp      = ref_mul(m, q);
        op_start = 1'b0;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        op_start     = 1'b1;
        exec_cycles  = 0;
        cyc          = 0;
        @(negedge clk);
        while (state == 2'b10 && cyc < LIMIT) begin
            exec_cycles++;
            cyc++;
            multiplicand = rnd64();
            multiplier   = rnd64();
            @(negedge clk);
        end
        check({tag, "_exec_cycles"}, (2*W)'(exec_cycles), (2*W)'(STEPS));
        check({tag, "_state_done"}, (2*W)'(state), (2*W)'(2'b01));
        check({tag, "_result"}, result, exp);
        repeat (3) begin
            multiplicand = rnd64();
            multiplier   = rnd64();
            @(negedge clk);
        end
        check({tag, "_done_hold_state"}, (2*W)'(state), (2*W)'(2'b01));
        check({tag, "_done_hold_result"}, result, exp);
        op_clear = 1'b1;
        op_start = 1'b0;
        @(negedge clk);
        check({tag, "_clear_state"}, (2*W)'(state), (2*W)'(2'b00));
        check({tag, "_clear_result"}, result, '0);
        op_clear = 1'b0;
    endtask

    initial begin
        int cyc;
        reset_n      = 1'b0;
        op_start     = 1'b1;
        op_clear     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        repeat (3) @(negedge clk);
        check("reset_state", (2*W)'(state), (2*W)'(2'b00));
        check("reset_result", result, '0);
        reset_n  = 1'b1;
        op_start = 1'b0;
        @(negedge clk);
        check("post_reset_state", (2*W)'(state), (2*W)'(2'b00));

        do_op("m3_q5", 64'd3, 64'd5);
        do_op("m-7_q6", -64'sd7, 64'd6);
        do_op("m-1_q-1", '1, '1);
        do_op("min_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        do_op("max_max", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
        do_op("min_max", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
        do_op("zero_q", rnd64(), 64'd0);

        // Abort on the 10th EXEC cycle
        op_start = 1'b0;
        @(negedge clk);
        multiplicand = rnd64();
        multiplier   = rnd64();
        op_start     = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (state == 2'b10 && cyc < 9) begin
            cyc++;
            @(negedge clk);
        end
        check("abort_reached_exec", (2*W)'(state), (2*W)'(2'b10));
        op_clear = 1'b1;
        op_start = 1'b0;
        @(negedge clk);
        check("abort_state", (2*W)'(state), (2*W)'(2'b00));
        check("abort_result", result, '0);
        op_clear = 1'b0;
        do_op("after_abort_2x2", 64'd2, 64'd2);

        // Clear wins over a start edge in IDLE; a held start level never re-triggers
        @(negedge clk);
        op_clear = 1'b1;
        op_start = 1'b1;
        @(negedge clk);
        check("idle_clear_prio_state", (2*W)'(state), (2*W)'(2'b00));
        op_clear = 1'b0;
        repeat (2) @(negedge clk);
        check("held_start_no_retrigger", (2*W)'(state), (2*W)'(2'b00));
        check("held_start_result", result, '0);

        // Reset mid-EXEC
        op_start = 1'b0;
        @(negedge clk);
        multiplicand = rnd64();
        multiplier   = rnd64();
        op_start     = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_reset_exec", (2*W)'(state), (2*W)'(2'b10));
        reset_n = 1'b0;
        #1;
        check("mid_reset_state", (2*W)'(state), (2*W)'(2'b00));
        check("mid_reset_result", result, '0);
        @(negedge clk);
        op_start = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        check("after_reset_idle", (2*W)'(state), (2*W)'(2'b00));

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("rand%0d", i), rnd64(), rnd64());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
